// File: rtl/bus_cycle_sequencer.sv
// T-state sequencer for the CPU pin controller: steps T1..T4 per machine cycle,
// inserts interrupt/IO/WAIT states, grants the bus between M-cycles, counts M-cycles.
module bus_cycle_sequencer #(
    parameter int IO_AUTO_WAIT = 1,
    parameter int MAX_M        = 6
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       mwait,
    input  logic       busrq,
    input  logic       in_intr,
    input  logic       last_m,
    input  logic       req_mread,
    input  logic       req_mwrite,
    input  logic       req_ioread,
    input  logic       req_iowrite,
    output logic       fFetch,
    output logic       fMRead,
    output logic       fMWrite,
    output logic       fIORead,
    output logic       fIOWrite,
    output logic       T1,
    output logic       T2,
    output logic       T3,
    output logic       T4,
    output logic       Tw1,
    output logic       Tw2,
    output logic       Twa,
    output logic       Tw,
    output logic       nextM,
    output logic       setM1,
    output logic       busack,
    output logic [2:0] m_num
);

    // Codes 0..7 double as bit positions of the strobe vector below.
    localparam logic [3:0] ST_T1     = 4'd0;
    localparam logic [3:0] ST_T2     = 4'd1;
    localparam logic [3:0] ST_T3     = 4'd2;
    localparam logic [3:0] ST_T4     = 4'd3;
    localparam logic [3:0] ST_TW1    = 4'd4;
    localparam logic [3:0] ST_TW2    = 4'd5;
    localparam logic [3:0] ST_TWA    = 4'd6;
    localparam logic [3:0] ST_TW     = 4'd7;
    localparam logic [3:0] ST_BUSACK = 4'd8;

    localparam logic [4:0] F_FETCH   = 5'b00001;
    localparam logic [4:0] F_MREAD   = 5'b00010;
    localparam logic [4:0] F_MWRITE  = 5'b00100;
    localparam logic [4:0] F_IOREAD  = 5'b01000;
    localparam logic [4:0] F_IOWRITE = 5'b10000;

    localparam logic [2:0] MAX_M_L   = 3'(MAX_M);

    logic [3:0] state_reg, state_next;
    logic [4:0] func_reg;
    logic [2:0] m_num_reg;
    logic [4:0] pend_func_reg;
    logic [2:0] pend_m_num_reg;

    logic       is_fetch;
    logic       is_io;
    logic       end_of_m;
    logic       enter_t1;
    logic [3:0] wait_next;
    logic [4:0] req_func;
    logic [2:0] req_m_num;
    logic [7:0] strobe_vec;

    assign is_fetch  = func_reg[0];
    assign is_io     = func_reg[3] | func_reg[4];
    assign end_of_m  = (state_reg == ST_T4) || ((state_reg == ST_T3) && !is_fetch);
    assign wait_next = mwait ? ST_TW : ST_T3;
    assign enter_t1  = (state_next == ST_T1) && (end_of_m || (state_reg == ST_BUSACK));

    // Function and M-cycle number of the cycle that follows the current one.
    always_comb begin
        req_func = F_MREAD;
        if (last_m)
            req_func = F_FETCH;
        else if (req_mread)
            req_func = F_MREAD;
        else if (req_mwrite)
            req_func = F_MWRITE;
        else if (req_ioread)
            req_func = F_IOREAD;
        else if (req_iowrite)
            req_func = F_IOWRITE;
    end

    always_comb begin
        req_m_num = m_num_reg + 3'd1;
        if (last_m)
            req_m_num = 3'd1;
        else if (m_num_reg >= MAX_M_L)
            req_m_num = MAX_M_L;
    end

    always_comb begin
        state_next = ST_T1;
        case (state_reg)
            ST_T1:  state_next = ST_T2;
            ST_T2: begin
                if (is_fetch && in_intr)
                    state_next = ST_TW1;
                else if (is_io && (IO_AUTO_WAIT != 0))
                    state_next = ST_TWA;
                else
                    state_next = wait_next;
            end
            ST_TW1: state_next = ST_TW2;
            ST_TW2, ST_TWA, ST_TW: state_next = wait_next;
            ST_T3: begin
                if (is_fetch)
                    state_next = ST_T4;
                else
                    state_next = busrq ? ST_BUSACK : ST_T1;
            end
            ST_T4:     state_next = busrq ? ST_BUSACK : ST_T1;
            ST_BUSACK: state_next = busrq ? ST_BUSACK : ST_T1;
            default:   state_next = ST_T1;
        endcase
    end

    // The next function is captured at the cycle boundary so a bus grant can
    // sit in between without the decoder holding last_m/req_* stable.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg      <= ST_T1;
            func_reg       <= F_FETCH;
            m_num_reg      <= 3'd1;
            pend_func_reg  <= F_FETCH;
            pend_m_num_reg <= 3'd1;
        end else begin
            state_reg <= state_next;
            if (end_of_m) begin
                pend_func_reg  <= req_func;
                pend_m_num_reg <= req_m_num;
            end
            if (enter_t1) begin
                func_reg  <= end_of_m ? req_func : pend_func_reg;
                m_num_reg <= end_of_m ? req_m_num : pend_m_num_reg;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_strobe
            assign strobe_vec[gi] = (state_reg == 4'(gi));
        end
    endgenerate

    assign T1  = strobe_vec[0];
    assign T2  = strobe_vec[1];
    assign T3  = strobe_vec[2];
    assign T4  = strobe_vec[3];
    assign Tw1 = strobe_vec[4];
    assign Tw2 = strobe_vec[5];
    assign Twa = strobe_vec[6];
    assign Tw  = strobe_vec[7];

    assign fFetch   = func_reg[0];
    assign fMRead   = func_reg[1];
    assign fMWrite  = func_reg[2];
    assign fIORead  = func_reg[3];
    assign fIOWrite = func_reg[4];

    assign nextM  = end_of_m;
    assign setM1  = end_of_m & last_m;
    assign busack = (state_reg == ST_BUSACK);
    assign m_num  = m_num_reg;

endmodule

// File: doc/bus_cycle_sequencer.md
Name: bus_cycle_sequencer

Overview:
Generates the per-M-cycle T-state strobes that drive the CPU pin controller. It latches the function of each machine cycle (fetch, memory read/write, IO read/write) and steps T1..T4. It inserts the automatic interrupt-acknowledge and IO wait states and extends cycles while WAIT is asserted. It also grants the bus on BUSRQ at machine-cycle boundaries and tracks the M-cycle number within an instruction.

Parameters:
IO_AUTO_WAIT, 1, number of automatic wait states (0 or 1) inserted after T2 in IO read/write cycles
MAX_M, 6, highest M-cycle number; m_num saturates here

Ports:
clk  in  1  CPU clock; all state changes on rising edge
nreset  in  1  asynchronous active-low reset
mwait  in  1  WAIT pin, positive internal polarity
busrq  in  1  BUSRQ pin, positive internal polarity
in_intr  in  1  current instruction is an interrupt acknowledge
last_m  in  1  decoder: current M-cycle is the last of the instruction
req_mread  in  1  next M-cycle is memory read
req_mwrite  in  1  next M-cycle is memory write
req_ioread  in  1  next M-cycle is IO read
req_iowrite  in  1  next M-cycle is IO write
fFetch, fMRead, fMWrite, fIORead, fIOWrite  out  1 each  one-hot function of the current M-cycle
T1, T2, T3, T4  out  1 each  one-hot T-state strobes
Tw1, Tw2  out  1 each  automatic interrupt-acknowledge waits in fetch
Twa  out  1  automatic IO wait
Tw  out  1  WAIT-extended state
nextM  out  1  high during the last T-state of every M-cycle
setM1  out  1  high during the last T-state when last_m=1
busack  out  1  bus granted
m_num  out  3  current M-cycle number, 1..MAX_M

Behaviour:
- Reset (nreset low, asynchronous):
  - state=T1, function=fFetch, m_num=1.
  - All other outputs are 0. T1=1 and fFetch=1 are held during reset.
  - After reset releases, the first rising edge advances to T2.
- Sequences, with [Tw]* meaning zero or more WAIT states:
  - Fetch, in_intr=0: T1 T2 [Tw]* T3 T4.
  - Fetch, in_intr=1: T1 T2 Tw1 Tw2 [Tw]* T3 T4.
  - MRead/MWrite: T1 T2 [Tw]* T3.
  - IORead/IOWrite: T1 T2 Twa (when IO_AUTO_WAIT=1) [Tw]* T3.
- WAIT test point: mwait is sampled on the rising edge leaving the test state.
  - Test state is T2 for fetch (in_intr=0) and for memory cycles, Tw2 for interrupt fetch, Twa for IO (or T2 when IO_AUTO_WAIT=0).
  - mwait=1 at the test edge: enter Tw.
  - In Tw, mwait is resampled each edge. Stay in Tw while it is 1; go to T3 when it is 0.
  - mwait is ignored in all other states.
- in_intr is sampled only at the T2 edge of a fetch.
- End of M-cycle: nextM=1 in the last T-state (T4 for fetch, T3 otherwise). On the edge leaving it:
  - If busrq=1: enter BUSACK. All T and Tw strobes are 0, busack=1 from the next cycle. The pending function and m_num are held.
  - Otherwise, or after leaving BUSACK: go to T1 of the next function.
    - last_m=1: next function is fFetch and m_num becomes 1.
    - last_m=0: next function is the req_* line, priority mread > mwrite > ioread > iowrite. With no req_* asserted, the next function is fMRead. m_num=min(m_num+1, MAX_M).
  - last_m and req_* are sampled on that same edge and captured for use after BUSACK.
- BUSACK: stays while busrq=1. The first edge with busrq=0 goes to T1 and clears busack simultaneously.
- Simultaneous events:
  - busrq asserted during a Tw state is not honoured until the end of the M-cycle.
  - busrq and mwait are never both acted on in one edge.
- Function outputs change only on the edge entering T1 and are constant for the whole M-cycle.
- Exactly one of T1..T4, Tw1, Tw2, Twa, Tw is high outside BUSACK. None is high in BUSACK.
- setM1 = nextM & last_m, combinational.

Test Plan:
- Reset then idle inputs, last_m=1: T1,T2,T3,T4 repeat every 4 clocks. fFetch=1, m_num=1, nextM and setM1 high in every T4.
- Fetch with last_m=0, req_mread=1, then last_m=1: fetch (4 clocks) then MRead T1 T2 T3 with m_num=2, then fetch with m_num=1.
- MWrite with mwait=1 for 3 sampled edges from T2: T1 T2 Tw Tw Tw T3 (6 clocks). Twa, Tw1 and Tw2 stay 0.
- IORead, IO_AUTO_WAIT=1, mwait=0: T1 T2 Twa T3 (4 clocks). Repeat with mwait=1 for one edge: 5 clocks.
- Fetch with in_intr=1: T1 T2 Tw1 Tw2 T3 T4 (6 clocks).
- busrq=1 before T4 edge, held 5 clocks: busack=1 for 5 clocks, no T strobes, then T1 with the captured function. Pulling nreset low mid-Tw gives T1/fFetch/m_num=1 immediately.
